// File: rtl/fm_rom_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fm_rom_lookup_arbiter
// Brief   : Shares one C-table ROM port and one Occ-table ROM port among
//           NUM_CH lanes using two independent round-robin arbiters.
// Revision: 1.0 - initial release
// ============================================================================
module fm_rom_lookup_arbiter #(
    parameter int NUM_CH = 4,
    parameter int OCC_AW = 8,
    parameter int OCC_DW = 32,
    parameter int C_AW   = 2,
    parameter int C_DW   = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req_valid_i,
    input  logic [NUM_CH-1:0]        req_type_i,
    input  logic [NUM_CH*OCC_AW-1:0] req_addr_i,
    output logic [NUM_CH-1:0]        req_ready_o,
    output logic [NUM_CH-1:0]        rsp_valid_o,
    output logic [NUM_CH*OCC_DW-1:0] rsp_data_o,
    output logic                     ce_rom_C_o,
    output logic [C_AW-1:0]          addr_rom_C_o,
    input  logic [C_DW-1:0]          data_c_i,
    output logic                     ce_rom_Occ_o,
    output logic [OCC_AW-1:0]        addr_rom_Occ_o,
    input  logic [OCC_DW-1:0]        data_occ_i,
    output logic [CNT_W-1:0]         occ_conflict_o,
    output logic [CNT_W-1:0]         c_conflict_o
);

    localparam int                 c_ptr_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [c_ptr_w-1:0] c_last  = c_ptr_w'(NUM_CH - 1);

    logic [NUM_CH-1:0]        w_occ_cand;
    logic [NUM_CH-1:0]        w_c_cand;
    logic [NUM_CH-1:0]        w_occ_gnt;
    logic [NUM_CH-1:0]        w_c_gnt;
    logic [c_ptr_w:0]         w_occ_pick;
    logic [c_ptr_w:0]         w_c_pick;
    logic                     w_occ_any;
    logic                     w_c_any;
    logic [c_ptr_w-1:0]       w_occ_idx;
    logic [c_ptr_w-1:0]       w_c_idx;
    logic [c_ptr_w-1:0]       w_occ_ptr_nxt;
    logic [c_ptr_w-1:0]       w_c_ptr_nxt;
    logic                     w_occ_multi;
    logic                     w_c_multi;
    logic [OCC_DW-1:0]        w_c_ext;

    logic [c_ptr_w-1:0]       r_occ_ptr;
    logic [c_ptr_w-1:0]       r_c_ptr;
    logic [NUM_CH-1:0]        r_rsp_valid;
    logic [NUM_CH*OCC_DW-1:0] r_rsp_data;
    logic [CNT_W-1:0]         r_occ_cnt;
    logic [CNT_W-1:0]         r_c_cnt;

    // Returns {found, index} of the first candidate at or after ptr (mod NUM_CH).
    // Iterating downward lets the lowest rotated offset overwrite the others.
    function automatic logic [c_ptr_w:0] f_rr_pick(
        input logic [NUM_CH-1:0]  cand,
        input logic [c_ptr_w-1:0] ptr
    );
        logic [c_ptr_w:0] res;
        int               j;
        res = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) begin
                j = j - NUM_CH;
            end
            if (cand[j]) begin
                res = {1'b1, j[c_ptr_w-1:0]};
            end
        end
        return res;
    endfunction

    assign w_occ_cand = req_valid_i & ~req_type_i;
    assign w_c_cand   = req_valid_i & req_type_i;

    assign w_occ_pick = f_rr_pick(w_occ_cand, r_occ_ptr);
    assign w_c_pick   = f_rr_pick(w_c_cand, r_c_ptr);
    assign w_occ_any  = w_occ_pick[c_ptr_w];
    assign w_c_any    = w_c_pick[c_ptr_w];
    assign w_occ_idx  = w_occ_pick[c_ptr_w-1:0];
    assign w_c_idx    = w_c_pick[c_ptr_w-1:0];

    assign w_occ_gnt = w_occ_any ? (NUM_CH'(1) << w_occ_idx) : '0;
    assign w_c_gnt   = w_c_any   ? (NUM_CH'(1) << w_c_idx)   : '0;

    assign w_occ_ptr_nxt = !w_occ_any         ? r_occ_ptr :
                           (w_occ_idx == c_last) ? '0 : w_occ_idx + 1'b1;
    assign w_c_ptr_nxt   = !w_c_any           ? r_c_ptr :
                           (w_c_idx == c_last)   ? '0 : w_c_idx + 1'b1;

    // x & (x-1) clears the lowest set bit, so non-zero means two or more candidates.
    assign w_occ_multi = |(w_occ_cand & (w_occ_cand - 1'b1));
    assign w_c_multi   = |(w_c_cand & (w_c_cand - 1'b1));

    always_comb begin
        w_c_ext           = '0;
        w_c_ext[C_DW-1:0] = data_c_i;
    end

    assign req_ready_o    = w_occ_gnt | w_c_gnt;
    assign ce_rom_Occ_o   = w_occ_any;
    assign ce_rom_C_o     = w_c_any;
    assign addr_rom_Occ_o = w_occ_any ? req_addr_i[w_occ_idx*OCC_AW +: OCC_AW] : '0;
    assign addr_rom_C_o   = w_c_any   ? req_addr_i[w_c_idx*OCC_AW +: C_AW]     : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ_ptr   <= '0;
            r_c_ptr     <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_occ_cnt   <= '0;
            r_c_cnt     <= '0;
        end else begin
            r_occ_ptr   <= w_occ_ptr_nxt;
            r_c_ptr     <= w_c_ptr_nxt;
            r_rsp_valid <= w_occ_gnt | w_c_gnt;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_occ_gnt[k]) begin
                    r_rsp_data[k*OCC_DW +: OCC_DW] <= data_occ_i;
                end else if (w_c_gnt[k]) begin
                    r_rsp_data[k*OCC_DW +: OCC_DW] <= w_c_ext;
                end
            end
            if (w_occ_multi && (r_occ_cnt != '1)) begin
                r_occ_cnt <= r_occ_cnt + 1'b1;
            end
            if (w_c_multi && (r_c_cnt != '1)) begin
                r_c_cnt <= r_c_cnt + 1'b1;
            end
        end
    end

    assign rsp_valid_o    = r_rsp_valid;
    assign rsp_data_o     = r_rsp_data;
    assign occ_conflict_o = r_occ_cnt;
    assign c_conflict_o   = r_c_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fm_rom_lookup_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fm_rom_lookup_arbiter
// Brief   : Directed self-checking bench for fm_rom_lookup_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fm_rom_lookup_arbiter;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int CAW = 2;
    localparam int CDW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_type;
    logic [N*AW-1:0] req_addr;

    logic [N-1:0]    ready,    s_ready;
    logic [N-1:0]    rsp_valid, s_rsp_valid;
    logic [N*DW-1:0] rsp_data, s_rsp_data;
    logic            ce_c, ce_occ, s_ce_c, s_ce_occ;
    logic [CAW-1:0]  addr_c, s_addr_c;
    logic [AW-1:0]   addr_occ, s_addr_occ;
    logic [CDW-1:0]  data_c, s_data_c;
    logic [DW-1:0]   data_occ, s_data_occ;
    logic [15:0]     occ_cnt, c_cnt;
    logic [3:0]      s_occ_cnt, s_c_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] occ_rom(input logic [AW-1:0] a);
        return {a, ~a, a ^ 8'hA5, 8'h3C};
    endfunction

    function automatic logic [CDW-1:0] c_rom(input logic [CAW-1:0] s);
        case (s)
            2'd0:    return 8'h9A;
            2'd1:    return 8'h2B;
            2'd2:    return 8'hC7;
            default: return 8'hE4;
        endcase
    endfunction

    assign data_occ   = occ_rom(addr_occ);
    assign data_c     = c_rom(addr_c);
    assign s_data_occ = occ_rom(s_addr_occ);
    assign s_data_c   = c_rom(s_addr_c);

    fm_rom_lookup_arbiter #(.NUM_CH(N), .OCC_AW(AW), .OCC_DW(DW), .C_AW(CAW),
                            .C_DW(CDW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_type_i(req_type), .req_addr_i(req_addr),
        .req_ready_o(ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .ce_rom_C_o(ce_c), .addr_rom_C_o(addr_c), .data_c_i(data_c),
        .ce_rom_Occ_o(ce_occ), .addr_rom_Occ_o(addr_occ), .data_occ_i(data_occ),
        .occ_conflict_o(occ_cnt), .c_conflict_o(c_cnt)
    );

    // Narrow-counter copy to observe saturation.
    fm_rom_lookup_arbiter #(.NUM_CH(N), .OCC_AW(AW), .OCC_DW(DW), .C_AW(CAW),
                            .C_DW(CDW), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_type_i(req_type), .req_addr_i(req_addr),
        .req_ready_o(s_ready), .rsp_valid_o(s_rsp_valid), .rsp_data_o(s_rsp_data),
        .ce_rom_C_o(s_ce_c), .addr_rom_C_o(s_addr_c), .data_c_i(s_data_c),
        .ce_rom_Occ_o(s_ce_occ), .addr_rom_Occ_o(s_addr_occ), .data_occ_i(s_data_occ),
        .occ_conflict_o(s_occ_cnt), .c_conflict_o(s_c_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int k, input logic v, input logic t, input logic [AW-1:0] a);
        req_valid[k]        = v;
        req_type[k]         = t;
        req_addr[k*AW +: AW] = a;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_type  = '0;
        req_addr  = '0;
    endtask

    logic [N-1:0] exp_oh;

    initial begin
        clear_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_data_lo", rsp_data[63:0], 64'h0);
        chk("rst_data_hi", rsp_data[127:64], 64'h0);
        chk("rst_occ_cnt", occ_cnt, 16'd0);
        chk("rst_c_cnt", c_cnt, 16'd0);
        rst = 1'b0;

        // Single Occ lookup on lane 2
        set_req(2, 1'b1, 1'b0, 8'h5A);
        settle();
        chk("t1_ready", ready, 4'b0100);
        chk("t1_ce_occ", ce_occ, 1'b1);
        chk("t1_addr_occ", addr_occ, 8'h5A);
        chk("t1_ce_c", ce_c, 1'b0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_data", rsp_data[2*DW +: DW], 32'h5AA5FF3C);
        set_req(2, 1'b0, 1'b0, 8'h00);

        // Simultaneous Occ (lane 0) and C (lane 1, upper address bits ignored)
        set_req(0, 1'b1, 1'b0, 8'h10);
        set_req(1, 1'b1, 1'b1, 8'hF3);
        settle();
        chk("t2_ready", ready, 4'b0011);
        chk("t2_ce", {ce_occ, ce_c}, 2'b11);
        chk("t2_addr_occ", addr_occ, 8'h10);
        chk("t2_addr_c", addr_c, 2'd3);
        tick();
        chk("t2_rsp_valid", rsp_valid, 4'b0011);
        chk("t2_data_l0", rsp_data[0 +: DW], 32'h10EFB53C);
        chk("t2_data_l1", rsp_data[DW +: DW], 32'h000000E4);
        chk("t2_data_l2_hold", rsp_data[2*DW +: DW], 32'h5AA5FF3C);
        chk("t2_counters", {occ_cnt, c_cnt}, 32'h0);
        clear_all();

        // Occ pointer is 1: lane 3 grant wraps it to 0, then it holds through idle
        set_req(3, 1'b1, 1'b0, 8'h33);
        settle();
        chk("t4_ready_l3", ready, 4'b1000);
        tick();
        chk("t4_rsp_l3", rsp_valid, 4'b1000);
        chk("t4_data_l3", rsp_data[3*DW +: DW], occ_rom(8'h33));
        clear_all();
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4_idle_ports", {ready, ce_occ, addr_occ, ce_c, addr_c}, 16'h0);
            tick();
            chk("t4_idle_rsp", rsp_valid, 4'b0000);
        end
        set_req(0, 1'b1, 1'b0, 8'h01);
        set_req(3, 1'b1, 1'b0, 8'h03);
        settle();
        chk("t4_wrap_ready", ready, 4'b0001);
        tick();
        chk("t4_wrap_rsp", rsp_valid, 4'b0001);
        chk("t4_occ_cnt", occ_cnt, 16'd1);
        set_req(0, 1'b0, 1'b0, 8'h00);
        settle();
        chk("t4_next_ready", ready, 4'b1000);
        tick();
        chk("t4_next_rsp", rsp_valid, 4'b1000);
        chk("t4_next_data", rsp_data[3*DW +: DW], occ_rom(8'h03));
        clear_all();

        // Reset while responses are in flight (Occ ptr 0 -> lane 1, C ptr 2 -> lane 2)
        set_req(1, 1'b1, 1'b0, 8'h77);
        set_req(2, 1'b1, 1'b1, 8'h01);
        settle();
        chk("t5_ready", ready, 4'b0110);
        tick();
        chk("t5_rsp_before_rst", rsp_valid, 4'b0110);
        clear_all();
        rst = 1'b1;
        settle();
        chk("t5_rsp_async", rsp_valid, 4'b0000);
        chk("t5_cnt_clear", {occ_cnt, c_cnt}, 32'h0);
        chk("t5_data_clear", rsp_data[63:0], 64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_no_stray", rsp_valid, 4'b0000);

        // Round-robin over four Occ requesters; first grant at lane 0 shows ptr reset
        for (int k = 0; k < N; k++) begin
            set_req(k, 1'b1, 1'b0, 8'h80 + 8'(k));
        end
        for (int n = 0; n < 8; n++) begin
            exp_oh = 4'b0001 << (n % 4);
            settle();
            chk("t3_ready", ready, exp_oh);
            tick();
            chk("t3_rsp", rsp_valid, exp_oh);
            chk("t3_data", rsp_data[(n % 4)*DW +: DW], occ_rom(8'h80 + 8'(n % 4)));
        end
        chk("t3_occ_cnt", occ_cnt, 16'd8);
        chk("t3_c_cnt", c_cnt, 16'd0);
        clear_all();

        // Saturation: two Occ and two C requesters held for 20 cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h01);
        set_req(2, 1'b1, 1'b1, 8'h02);
        set_req(3, 1'b1, 1'b1, 8'h03);
        settle();
        chk("t6_ready0", ready, 4'b0101);
        tick();
        settle();
        chk("t6_ready1", ready, 4'b1010);
        repeat (14) tick();
        chk("t6_sat_occ_15", s_occ_cnt, 4'd15);
        chk("t6_sat_c_15", s_c_cnt, 4'd15);
        repeat (5) tick();
        chk("t6_sat_occ_hold", s_occ_cnt, 4'd15);
        chk("t6_sat_c_hold", s_c_cnt, 4'd15);
        chk("t6_wide_occ", occ_cnt, 16'd20);
        chk("t6_wide_c", c_cnt, 16'd20);
        clear_all();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
